// File: rtl/gfx_pixel_writer_pkg.sv
// Shared constants, FSM state encoding and small helpers for the pixel writer.
package gfx_pixel_writer_pkg;

    localparam int DEF_FB_WIDTH   = 640;
    localparam int DEF_FB_HEIGHT  = 480;
    localparam int DEF_COLOR_BITS = 12;
    localparam int DEF_ADDR_BITS  = 20;
    localparam int DEF_DATA_BITS  = 16;
    localparam int CLIP_W         = 16;

    localparam logic [CLIP_W-1:0] CLIP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_WE   = 2'd3
    } wr_state_e;

    function automatic logic [CLIP_W-1:0] sat_inc(input logic [CLIP_W-1:0] val);
        logic [CLIP_W-1:0] res;
        if (val == CLIP_MAX) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gfx_pixel_writer_if.sv
// Pixel stream, SRAM bus and status signals of the pixel writer.
interface gfx_pixel_writer_if
    import gfx_pixel_writer_pkg::*;
#(
    parameter int X_W        = $clog2(DEF_FB_WIDTH),
    parameter int Y_W        = $clog2(DEF_FB_HEIGHT),
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
);
    logic                  pix_valid;
    logic                  pix_ready;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic [COLOR_BITS-1:0] pix_color;
    logic                  pix_last;
    logic                  mem_req;
    logic                  mem_grant;
    logic [ADDR_BITS-1:0]  sram_addr;
    logic [DATA_BITS-1:0]  sram_wdata;
    logic                  sram_we_n;
    logic                  line_done;
    logic [CLIP_W-1:0]     clip_count;

    // Rasterizer plus arbiter side.
    modport master (
        output pix_valid, pix_x, pix_y, pix_color, pix_last, mem_grant,
        input  pix_ready, mem_req, sram_addr, sram_wdata, sram_we_n, line_done, clip_count
    );

    // Pixel writer side.
    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, pix_last, mem_grant,
        output pix_ready, mem_req, sram_addr, sram_wdata, sram_we_n, line_done, clip_count
    );

endinterface

// File: rtl/gfx_pixel_fifo.sv
// Generic 2-entry synchronous FIFO; full/empty are registered flags so the
// producer-facing ready never depends combinationally on the consumer.
module gfx_pixel_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [1:0]       w_count_nxt;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    // Occupancy update for every push/pop combination.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= {WIDTH{1'b0}};
            r_mem[1] <= {WIDTH{1'b0}};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == 2'd2);
            r_empty <= (w_count_nxt == 2'd0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/gfx_pixel_writer.sv
// Clips buffered rasterizer pixels to the framebuffer and turns each surviving
// pixel into one arbitrated external-SRAM write strobe.
module gfx_pixel_writer
    import gfx_pixel_writer_pkg::*;
#(
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic              clk,
    input  logic              reset,
    gfx_pixel_writer_if.slave bus
);

    localparam int X_W   = $clog2(FB_WIDTH);
    localparam int Y_W   = $clog2(FB_HEIGHT);
    localparam int ENT_W = X_W + Y_W + COLOR_BITS + 1;

    logic [ENT_W-1:0]      w_push_data;
    logic [ENT_W-1:0]      w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [X_W-1:0]        w_head_x;
    logic [Y_W-1:0]        w_head_y;
    logic [COLOR_BITS-1:0] w_head_color;
    logic                  w_head_last;
    logic                  w_head_clip;
    logic [ADDR_BITS-1:0]  w_head_addr;
    logic                  w_load;
    logic                  w_clip_evt;

    wr_state_e             r_state;
    wr_state_e             w_state_nxt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_BITS-1:0]  r_wdata;
    logic                  r_last;
    logic                  r_mem_req;
    logic                  r_we_n;
    logic                  r_line_done;
    logic [CLIP_W-1:0]     r_clip_count;

    // y*FB_WIDTH as a sum of shifted copies of y, one per set bit of the constant.
    function automatic logic [ADDR_BITS-1:0] row_base(input logic [Y_W-1:0] y);
        logic [ADDR_BITS-1:0] acc;
        logic [ADDR_BITS-1:0] y_ext;
        acc   = {ADDR_BITS{1'b0}};
        y_ext = ADDR_BITS'(y);
        for (int i = 0; i < 32; i++) begin
            if (FB_WIDTH[i]) begin
                acc = acc + (y_ext << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    assign w_push      = bus.pix_valid & ~w_full;
    assign w_push_data = {bus.pix_last, bus.pix_color, bus.pix_y, bus.pix_x};

    gfx_pixel_fifo #(
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_last, w_head_color, w_head_y, w_head_x} = w_head;

    assign w_head_clip = (32'(w_head_x) >= FB_WIDTH) || (32'(w_head_y) >= FB_HEIGHT);
    assign w_head_addr = row_base(w_head_y) + ADDR_BITS'(w_head_x);

    // Next-state, pop and clip decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_clip_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_clip) begin
                        w_clip_evt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_grant) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_ADDR: begin
                if (bus.mem_grant) begin
                    w_state_nxt = ST_WE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WE: begin
                // The strobe always completes; grant is not consulted here.
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_clip) begin
                        w_clip_evt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write address/data/last captured at pop, held through ADDR and WE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= {ADDR_BITS{1'b0}};
            r_wdata <= {DATA_BITS{1'b0}};
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_addr  <= w_head_addr;
            r_wdata <= DATA_BITS'(w_head_color);
            r_last  <= w_head_last;
        end
    end

    // Registered bus controls decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req <= 1'b0;
            r_we_n    <= 1'b1;
        end else begin
            r_mem_req <= (w_state_nxt != ST_IDLE);
            r_we_n    <= (w_state_nxt != ST_WE);
        end
    end

    // Line completion pulse and saturating discard counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_done  <= 1'b0;
            r_clip_count <= {CLIP_W{1'b0}};
        end else begin
            r_line_done <= ((r_state == ST_WE) && r_last) || (w_clip_evt && w_head_last);
            if (w_clip_evt) begin
                r_clip_count <= sat_inc(r_clip_count);
            end
        end
    end

    assign bus.pix_ready  = ~w_full;
    assign bus.mem_req    = r_mem_req;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;
    assign bus.sram_we_n  = r_we_n;
    assign bus.line_done  = r_line_done;
    assign bus.clip_count = r_clip_count;

endmodule

// File: tb/tb_gfx_pixel_writer.sv
// Directed, table-driven bench for gfx_pixel_writer with an SRAM write monitor.
module tb_gfx_pixel_writer;
    import gfx_pixel_writer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gfx_pixel_writer_if bus ();

    gfx_pixel_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          x;
        int          y;
        int          color;
        bit          last;
        logic [19:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t line_v [11];
    vec_t hold_v [3];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ld_cnt  = 0;
    int ld_cyc  = -1;
    logic [19:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int          wq_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sram_we_n == 1'b0) begin
            wq_addr.push_back(bus.sram_addr);
            wq_data.push_back(bus.sram_wdata);
            wq_cyc.push_back(cyc);
        end
        if (bus.line_done == 1'b1) begin
            ld_cnt = ld_cnt + 1;
            ld_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic send(input int x, input int y, input int color, input bit last);
        int t;
        t = 0;
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 9'(y);
        bus.pix_color = 12'(color);
        bus.pix_last  = last;
        while (!bus.pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_writes(input string name, input int n, input int limit);
        int t;
        t = 0;
        while (wq_addr.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(wq_addr.size()), 32'(n));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int ld0;
        int seen;
        for (int i = 0; i < 11; i++) begin
            line_v[i] = '{10 + i, 10, 'hABC, (i == 10), 20'd6410 + 20'(i), 16'h0ABC};
        end
        hold_v[0] = '{0,   0,   'h123, 1'b0, 20'd0,      16'h0123};
        hold_v[1] = '{639, 479, 'hFFF, 1'b0, 20'd307199, 16'h0FFF};
        hold_v[2] = '{5,   1,   'h001, 1'b1, 20'd645,    16'h0001};

        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_x     = 10'd0;
        bus.pix_y     = 9'd0;
        bus.pix_color = 12'd0;
        bus.pix_last  = 1'b0;
        bus.mem_grant = 1'b0;

        // Reset values
        idle_cycles(3);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("rst_clip_count", 32'(bus.clip_count), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_line_done", 32'(bus.line_done), 32'd0);
        reset = 1'b1;
        idle_cycles(2);
        check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);

        // Horizontal line with grant held
        bus.mem_grant = 1'b1;
        clear_writes();
        ld0 = ld_cnt;
        for (int i = 0; i < 11; i++) send(line_v[i].x, line_v[i].y, line_v[i].color, line_v[i].last);
        wait_writes("line_nwrites", 11, 200);
        idle_cycles(4);
        check("line_nwrites_final", 32'(wq_addr.size()), 32'd11);
        for (int i = 0; i < 11 && i < wq_addr.size(); i++) begin
            check($sformatf("line_addr[%0d]", i), 32'(wq_addr[i]), 32'(line_v[i].exp_addr));
            check($sformatf("line_data[%0d]", i), 32'(wq_data[i]), 32'(line_v[i].exp_data));
            if (i > 0) check($sformatf("line_spacing[%0d]", i), 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd2);
        end
        check("line_done_count", 32'(ld_cnt - ld0), 32'd1);
        if (wq_cyc.size() == 11) check("line_done_timing", 32'(ld_cyc), 32'(wq_cyc[10] + 1));
        check("line_mem_req_idle", 32'(bus.mem_req), 32'd0);

        // Clipping
        clear_writes();
        ld0 = ld_cnt;
        send(700, 5, 'h111, 1'b0);
        send(3, 500, 'h222, 1'b1);
        idle_cycles(8);
        check("clip_nwrites", 32'(wq_addr.size()), 32'd0);
        check("clip_count", 32'(bus.clip_count), 32'd2);
        check("clip_line_done", 32'(ld_cnt - ld0), 32'd1);

        // Grant withheld with three pixels offered
        bus.mem_grant = 1'b0;
        clear_writes();
        for (int i = 0; i < 3; i++) send(hold_v[i].x, hold_v[i].y, hold_v[i].color, hold_v[i].last);
        @(negedge clk);
        check("hold_pix_ready", 32'(bus.pix_ready), 32'd0);
        idle_cycles(10);
        check("hold_mem_req", 32'(bus.mem_req), 32'd1);
        check("hold_nwrites", 32'(wq_addr.size()), 32'd0);
        check("hold_pix_ready_late", 32'(bus.pix_ready), 32'd0);
        bus.mem_grant = 1'b1;
        wait_writes("hold_nwrites_after", 3, 50);
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            check($sformatf("hold_addr[%0d]", i), 32'(wq_addr[i]), 32'(hold_v[i].exp_addr));
            check($sformatf("hold_data[%0d]", i), 32'(wq_data[i]), 32'(hold_v[i].exp_data));
        end
        idle_cycles(4);

        // Grant dropped while in ADDR
        bus.mem_grant = 1'b0;
        clear_writes();
        send(100, 200, 'h5A5, 1'b0);
        idle_cycles(3);
        check("drop_mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_grant = 1'b1;
        @(negedge clk);
        bus.mem_grant = 1'b0;
        idle_cycles(6);
        check("drop_nwrites", 32'(wq_addr.size()), 32'd0);
        check("drop_we_n", 32'(bus.sram_we_n), 32'd1);
        check("drop_mem_req_held", 32'(bus.mem_req), 32'd1);
        bus.mem_grant = 1'b1;
        wait_writes("drop_nwrites_after", 1, 20);
        if (wq_addr.size() >= 1) begin
            check("drop_addr", 32'(wq_addr[0]), 32'd128100);
            check("drop_data", 32'(wq_data[0]), 32'h05A5);
        end
        idle_cycles(4);

        // Reset asserted during the strobe
        send(1, 2, 'h0F0, 1'b0);
        send(2, 2, 'h0F1, 1'b0);
        send(3, 2, 'h0F2, 1'b1);
        seen = 0;
        for (int t = 0; t < 50 && seen == 0; t++) begin
            @(negedge clk);
            if (bus.sram_we_n == 1'b0) seen = 1;
        end
        check("mid_saw_strobe", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_we_n_async", 32'(bus.sram_we_n), 32'd1);
        check("mid_mem_req_async", 32'(bus.mem_req), 32'd0);
        idle_cycles(2);
        reset = 1'b1;
        clear_writes();
        idle_cycles(20);
        check("mid_nwrites_after", 32'(wq_addr.size()), 32'd0);
        check("mid_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("mid_mem_req", 32'(bus.mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
